soc_bus_interconnect: RTL and testbench

Single-master, multi-slave memory-bus interconnect between the Core and N memory-mapped slaves (RAM, UART, GPIO, timer).
- Replaces direct Core-to-Memory wiring.
- Adds parametrised address decode, a per-slave request/ack handshake, and error responses for unmapped or unresponsive addresses.
- One outstanding transaction at a time; the response is registered.

---
 rtl/soc_bus_interconnect.sv | 202 ++++++++++++++++++++
 tb/tb_soc_bus_interconnect.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus_interconnect.sv
// soc_bus_interconnect: single-master, multi-slave memory-bus interconnect.
// A master request is latched in IDLE, decoded against per-slave base/mask
// pairs, forwarded to the matching slave as a held one-hot strobe, and
// answered with a registered one-cycle memory_ack (qualified by bus_error).
// Unmapped addresses are answered directly with ERROR_DATA.
// Optional feature macro: INTERCONNECT_TIMEOUT_EN -- when defined, an ACCESS
// that sees no slave_ack for TIMEOUT_CYCLES cycles is aborted with bus_error.
// Note: the port named 'reset' is an asynchronous, active-low reset.

module soc_bus_interconnect #(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h30000000, 32'h20000000, 32'h10000000, 32'h00000000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFF000},
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERROR_DATA = 32'hDEADBEEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             memory_read,
  input  logic                             memory_write,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic [DATA_WIDTH-1:0]            write_data,
  output logic [DATA_WIDTH-1:0]            read_data,
  output logic                             memory_ack,
  output logic                             bus_error,
  output logic [NUM_SLAVES-1:0]            slave_read,
  output logic [NUM_SLAVES-1:0]            slave_write,
  output logic [ADDR_WIDTH-1:0]            slave_address,
  output logic [DATA_WIDTH-1:0]            slave_write_data,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_read_data,
  input  logic [NUM_SLAVES-1:0]            slave_ack
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  // Reject configurations the decode/select logic cannot represent.
  if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("soc_bus_interconnect: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    is_write_q, is_write_d;
  logic                    error_q, error_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

`ifdef INTERCONNECT_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

  logic                    hit;
  logic [SEL_W-1:0]        hit_idx;
  logic                    ack_sel;
  logic [DATA_WIDTH-1:0]   rdata_sel;
  logic [NUM_SLAVES-1:0]   sel_onehot;

  // Address decode; scanning from the top down lets the lowest match win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((address & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  // Select ack, read data and strobe position of the latched slave only.
  always_comb begin
    ack_sel    = 1'b0;
    rdata_sel  = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (SEL_W'(i) == sel_q) begin
        ack_sel       = slave_ack[i];
        rdata_sel     = slave_read_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and datapath updates for the IDLE/ACCESS/RESPOND sequence.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    is_write_d = is_write_q;
    error_d    = error_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
`ifdef INTERCONNECT_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (memory_read || memory_write) begin
          addr_d     = address;
          wdata_d    = write_data;
          is_write_d = memory_write;
          if (hit) begin
            sel_d   = hit_idx;
            error_d = 1'b0;
            state_d = ACCESS;
`ifdef INTERCONNECT_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            error_d = 1'b1;
            rdata_d = ERROR_DATA;
            state_d = RESPOND;
          end
        end
      end
      ACCESS: begin
        if (ack_sel) begin
          if (!is_write_q) begin
            rdata_d = rdata_sel;
          end
          error_d = 1'b0;
          state_d = RESPOND;
        end
`ifdef INTERCONNECT_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            error_d = 1'b1;
            rdata_d = ERROR_DATA;
            state_d = RESPOND;
          end
        end
`endif
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      is_write_q <= 1'b0;
      error_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
`ifdef INTERCONNECT_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      is_write_q <= is_write_d;
      error_q    <= error_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
`ifdef INTERCONNECT_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Outputs derive from registered state so strobes drop the moment reset hits.
  always_comb begin
    slave_read  = '0;
    slave_write = '0;
    if (state_q == ACCESS) begin
      if (is_write_q) begin
        slave_write = sel_onehot;
      end else begin
        slave_read = sel_onehot;
      end
    end
    memory_ack       = (state_q == RESPOND);
    bus_error        = (state_q == RESPOND) && error_q;
    read_data        = rdata_q;
    slave_address    = addr_q;
    slave_write_data = wdata_q;
  end

endmodule

// File: tb/tb_soc_bus_interconnect.sv
// tb_soc_bus_interconnect: scoreboard-based bench for soc_bus_interconnect.
// Each transaction pushes its expected response into a queue when driven;
// the entry is popped and compared when memory_ack appears. A reactive
// slave model answers the selected slot after a programmable wait count.

module tb_soc_bus_interconnect;

  localparam int NS  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  logic           clk = 1'b0;
  logic           reset;
  logic           memory_read;
  logic           memory_write;
  logic [AW-1:0]  address;
  logic [DW-1:0]  write_data;
  logic [DW-1:0]  read_data;
  logic           memory_ack;
  logic           bus_error;
  logic [NS-1:0]  slave_read;
  logic [NS-1:0]  slave_write;
  logic [AW-1:0]  slave_address;
  logic [DW-1:0]  slave_write_data;
  logic [NS*DW-1:0] slave_read_data;
  logic [NS-1:0]  slave_ack;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          latency;
    int          strobes;
    logic [3:0]  rd_mask;
    logic [3:0]  wr_mask;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_rdata;
  time         last_ack_time;

  soc_bus_interconnect #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .memory_read(memory_read), .memory_write(memory_write),
    .address(address), .write_data(write_data),
    .read_data(read_data), .memory_ack(memory_ack), .bus_error(bus_error),
    .slave_read(slave_read), .slave_write(slave_write),
    .slave_address(slave_address), .slave_write_data(slave_write_data),
    .slave_read_data(slave_read_data), .slave_ack(slave_ack)
  );

  always #5 clk = ~clk;

  // One master transaction. slot=-1 means unmapped, waits=-1 means never ack.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int slot, input int waits,
                         input logic [31:0] ack_data, input logic [3:0] stray_ack,
                         input string name);
    exp_t       e;
    exp_t       got;
    logic [3:0] mask;
    int         strobe_cnt;
    bit         done;
    logic [3:0] exp_rd;
    logic [3:0] exp_wr;
    mask      = (slot >= 0) ? (4'b0001 << slot) : 4'b0000;
    e.rd_mask = (rd && !wr) ? mask : 4'b0000;
    e.wr_mask = wr ? mask : 4'b0000;
    if (slot < 0) begin
      e.err = 1'b1; e.data = ERR_WORD; e.strobes = 0; e.latency = 1;
    end else if (waits < 0) begin
      e.err = 1'b1; e.data = ERR_WORD; e.strobes = TMO; e.latency = TMO + 1;
    end else begin
      e.err = 1'b0; e.data = wr ? model_rdata : ack_data;
      e.strobes = waits + 1; e.latency = waits + 2;
    end
    model_rdata = e.data;
    sb.push_back(e);

    @(negedge clk);
    memory_read  = rd;
    memory_write = wr;
    address      = addr;
    write_data   = wdata;
    strobe_cnt   = 0;
    done         = 1'b0;
    for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
      @(negedge clk);
      exp_rd = (cyc <= e.strobes) ? e.rd_mask : 4'b0000;
      exp_wr = (cyc <= e.strobes) ? e.wr_mask : 4'b0000;
      tests++;
      if (slave_read !== exp_rd) begin
        fails++;
        $display("[TB] FAIL %s slave_read cyc%0d: got %b expected %b", name, cyc, slave_read, exp_rd);
      end
      tests++;
      if (slave_write !== exp_wr) begin
        fails++;
        $display("[TB] FAIL %s slave_write cyc%0d: got %b expected %b", name, cyc, slave_write, exp_wr);
      end
      if (cyc <= e.strobes) begin
        tests++;
        if (slave_address !== addr) begin
          fails++;
          $display("[TB] FAIL %s slave_address: got %h expected %h", name, slave_address, addr);
        end
        if (wr) begin
          tests++;
          if (slave_write_data !== wdata) begin
            fails++;
            $display("[TB] FAIL %s slave_write_data: got %h expected %h", name, slave_write_data, wdata);
          end
        end
      end
      if (memory_ack === 1'b1) begin
        got = sb.pop_front();
        last_ack_time = $time;
        tests++;
        if (cyc != got.latency) begin
          fails++;
          $display("[TB] FAIL %s ack latency: got %0d expected %0d", name, cyc, got.latency);
        end
        tests++;
        if (bus_error !== got.err) begin
          fails++;
          $display("[TB] FAIL %s bus_error: got %b expected %b", name, bus_error, got.err);
        end
        tests++;
        if (read_data !== got.data) begin
          fails++;
          $display("[TB] FAIL %s read_data: got %h expected %h", name, read_data, got.data);
        end
        memory_read  = 1'b0;
        memory_write = 1'b0;
        done         = 1'b1;
      end
      // Slave model: ack the selected slot once its wait count has elapsed.
      slave_ack = 4'b0000;
      if (slot >= 0 && (slave_read[slot] || slave_write[slot])) begin
        strobe_cnt++;
        if (waits >= 0 && strobe_cnt > waits) begin
          slave_ack[slot] = 1'b1;
          slave_read_data[slot*DW +: DW] = ack_data;
        end
        slave_ack = slave_ack | stray_ack;
      end
    end
    slave_ack = 4'b0000;
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s no memory_ack within cycle budget: got none expected one", name);
      void'(sb.pop_front());
      memory_read  = 1'b0;
      memory_write = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string name, input logic [31:0] exp_rdata);
    tests++;
    if ({slave_read, slave_write, memory_ack, bus_error} !== 10'b0) begin
      fails++;
      $display("[TB] FAIL %s strobes/ack: got %b expected 0", name, {slave_read, slave_write, memory_ack, bus_error});
    end
    tests++;
    if (read_data !== exp_rdata) begin
      fails++;
      $display("[TB] FAIL %s read_data: got %h expected %h", name, read_data, exp_rdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    memory_read = 1'b0; memory_write = 1'b0;
    address = '0; write_data = '0;
    slave_ack = '0; slave_read_data = '0;
    model_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 32'h0);
    tests++;
    if ({slave_address, slave_write_data} !== 64'h0) begin
      fails++;
      $display("[TB] FAIL reset latched addr/data: got %h expected 0", {slave_address, slave_write_data});
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_release", 32'h0);
  endtask

  task automatic test_read_zero_wait();
    run_txn(1'b1, 1'b0, 32'h00000010, 32'h0, 0, 0, 32'h12345678, 4'b0000, "read_slave0");
  endtask

  task automatic test_write_wait();
    run_txn(1'b0, 1'b1, 32'h10000004, 32'h000000AA, 1, 3, 32'h0, 4'b0000, "write_slave1");
  endtask

  task automatic test_unmapped();
    run_txn(1'b1, 1'b0, 32'h40000000, 32'h0, -1, 0, 32'h0, 4'b0000, "unmapped_read");
  endtask

  task automatic test_read_write_both();
    run_txn(1'b1, 1'b1, 32'h20000000, 32'h00000055, 2, 1, 32'h0, 4'b0001, "rd_wr_both");
  endtask

  task automatic test_decode_boundaries();
    run_txn(1'b1, 1'b0, 32'h00000FFC, 32'h0, 0, 0, 32'hA0A0A0A0, 4'b0000, "slot0_top");
    run_txn(1'b1, 1'b0, 32'h00001000, 32'h0, -1, 0, 32'h0, 4'b0000, "slot0_past");
    run_txn(1'b1, 1'b0, 32'h100000FF, 32'h0, 1, 2, 32'hB1B1B1B1, 4'b0000, "slot1_top");
    run_txn(1'b1, 1'b0, 32'h10000100, 32'h0, -1, 0, 32'h0, 4'b0000, "slot1_past");
  endtask

  task automatic test_back_to_back();
    time t_prev;
    run_txn(1'b1, 1'b0, 32'h30000040, 32'h0, 3, 0, 32'h11110000, 4'b0000, "b2b_0");
    for (int k = 1; k < 4; k++) begin
      t_prev = last_ack_time;
      run_txn(k[0] ? 1'b0 : 1'b1, k[0], 32'h30000040 + 32'(k * 4), 32'h0000C000 + 32'(k),
              3, 0, 32'h11110000 + 32'(k), 4'b0000, "b2b");
      tests++;
      if (last_ack_time - t_prev != 30) begin
        fails++;
        $display("[TB] FAIL b2b ack spacing: got %0t expected 30", last_ack_time - t_prev);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    memory_read = 1'b1;
    address     = 32'h20000010;
    @(negedge clk);
    tests++;
    if (slave_read !== 4'b0100) begin
      fails++;
      $display("[TB] FAIL reset_mid strobe before reset: got %b expected 0100", slave_read);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_idle_outputs("reset_mid", 32'h0);
    tests++;
    if (slave_address !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_mid slave_address: got %h expected 0", slave_address);
    end
    memory_read = 1'b0;
    address     = '0;
    model_rdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_txn(1'b1, 1'b0, 32'h20000020, 32'h0, 2, 0, 32'h5A5A1234, 4'b0000, "after_reset");
  endtask

`ifdef INTERCONNECT_TIMEOUT_EN
  task automatic test_timeout();
    run_txn(1'b1, 1'b0, 32'h30000000, 32'h0, 3, -1, 32'h0, 4'b0000, "timeout");
    @(negedge clk);
    @(negedge clk);
    slave_ack = 4'b1000;
    slave_read_data[3*DW +: DW] = 32'h77777777;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      slave_ack = 4'b0000;
      check_idle_outputs("late_ack", ERR_WORD);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_unmapped();
    test_read_write_both();
    test_decode_boundaries();
    test_back_to_back();
    test_reset_mid();
`ifdef INTERCONNECT_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
